// File: rtl/reg_file_2r1w.sv
// Architectural register bank: DEPTH x WIDTH flip-flop entries, one
// byte-masked write port and two independent registered read ports with
// write-first bypass. Entry 0 can be hardwired to zero.
module reg_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   WAddr,
  input  logic [WIDTH-1:0]    WData,
  input  logic [WIDTH/8-1:0]  WMask,
  input  logic                RE0,
  input  logic [ADDR_W-1:0]   RAddr0,
  output logic [WIDTH-1:0]    RData0,
  input  logic                RE1,
  input  logic [ADDR_W-1:0]   RAddr1,
  output logic [WIDTH-1:0]    RData1
);

  localparam int LANES = WIDTH / 8;

  // Parameter sanity: any violation stops elaboration.
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("reg_file_2r1w: WIDTH must be a positive multiple of 8");
  end
  if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $error("reg_file_2r1w: DEPTH must be in 2..256");
  end
  if (ADDR_W > 8 || ADDR_W < $clog2(DEPTH)) begin : g_bad_addr
    $error("reg_file_2r1w: ADDR_W must satisfy clog2(DEPTH) <= ADDR_W <= 8");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;

  // True when the address names a physical entry.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (9'(a) < 9'(DEPTH));
  endfunction

  // True when the address is the hardwired-zero entry.
  function automatic logic addr_is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Mux lookup over the entries; out-of-range addresses return 0. Looping
  // over DEPTH avoids indexing the array with a wider-than-needed address.
  function automatic logic [WIDTH-1:0] entry_lookup(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) v = mem[i];
    end
    return v;
  endfunction

  // Value a read port loads this edge: zero entry and out-of-range read as 0,
  // a same-address write forwards the merged word.
  function automatic logic [WIDTH-1:0] read_value(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    if (!addr_in_range(a) || addr_is_zero_reg(a)) begin
      v = '0;
    end else if (wr_ok && (a == WAddr)) begin
      v = wr_merged;
    end else begin
      v = entry_lookup(a);
    end
    return v;
  endfunction

  // Write qualification and byte-lane merge of new data over the old entry.
  always_comb begin
    wr_ok     = WE && addr_in_range(WAddr) && !addr_is_zero_reg(WAddr);
    wr_old    = entry_lookup(WAddr);
    wr_merged = wr_old;
    for (int b = 0; b < LANES; b++) begin
      if (WMask[b]) wr_merged[b*8 +: 8] = WData[b*8 +: 8];
    end
  end

  // Entry storage: reset clears everything, otherwise commit the merged word.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WAddr == ADDR_W'(i)) mem[i] <= wr_merged;
      end
    end
  end

  // Read port 0 output register; holds when not enabled.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RData0 <= '0;
    end else if (RE0) begin
      RData0 <= read_value(RAddr0);
    end
  end

  // Read port 1 output register; holds when not enabled.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RData1 <= '0;
    end else if (RE1) begin
      RData1 <= read_value(RAddr1);
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w. Three instances share one stimulus:
// the default configuration, ZERO_REG=0, and a DEPTH=20 file.
module tb_reg_file_2r1w;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        re0;
  logic [4:0]  raddr0;
  logic        re1;
  logic [4:0]  raddr1;

  logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b, rd0_c, rd1_c;

  int n_cmp;
  int n_bad;

  logic [31:0] exp_c [20];

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)) dut_a (
    .Clock(clk), .Reset(rst), .WE(we), .WAddr(waddr), .WData(wdata), .WMask(wmask),
    .RE0(re0), .RAddr0(raddr0), .RData0(rd0_a),
    .RE1(re1), .RAddr1(raddr1), .RData1(rd1_a)
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0)) dut_b (
    .Clock(clk), .Reset(rst), .WE(we), .WAddr(waddr), .WData(wdata), .WMask(wmask),
    .RE0(re0), .RAddr0(raddr0), .RData0(rd0_b),
    .RE1(re1), .RAddr1(raddr1), .RData1(rd1_b)
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_REG(1)) dut_c (
    .Clock(clk), .Reset(rst), .WE(we), .WAddr(waddr), .WData(wdata), .WMask(wmask),
    .RE0(re0), .RAddr0(raddr0), .RData0(rd0_c),
    .RE1(re1), .RAddr1(raddr1), .RData1(rd1_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; re0 = 1'b0; re1 = 1'b0;
    waddr = '0; wdata = '0; wmask = '0; raddr0 = '0; raddr1 = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1'b1;
    step();
    check_val("reset_rd0_a", rd0_a, 32'h0);
    check_val("reset_rd1_a", rd1_a, 32'h0);
    rst = 1'b0;

    // First read after reset returns 0.
    re0 = 1'b1; raddr0 = 5'd5; re1 = 1'b1; raddr1 = 5'd31;
    step();
    check_val("post_reset_rd0", rd0_a, 32'h0);
    check_val("post_reset_rd1", rd1_a, 32'h0);
    check_val("post_reset_c_oor", rd1_c, 32'h0);

    // Byte-masked overwrite.
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; wmask = 4'b1111;
    step();
    wdata = 32'h11223344; wmask = 4'b0101;
    step();
    idle();
    re0 = 1'b1; raddr0 = 5'd7;
    step();
    check_val("mask_merge_a", rd0_a, 32'hDE22BE44);
    check_val("mask_merge_c", rd0_c, 32'hDE22BE44);

    // All-zero mask writes nothing; bypass returns the unchanged word.
    we = 1'b1; waddr = 5'd7; wdata = 32'h0; wmask = 4'b0000;
    re0 = 1'b1; raddr0 = 5'd7;
    step();
    check_val("mask_zero", rd0_a, 32'hDE22BE44);

    // Write-first bypass on both ports.
    idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'hAAAAAAAA; wmask = 4'b1111;
    step();
    wdata = 32'h12345678; wmask = 4'b0011;
    re0 = 1'b1; raddr0 = 5'd3; re1 = 1'b1; raddr1 = 5'd3;
    step();
    check_val("bypass_rd0", rd0_a, 32'hAAAA5678);
    check_val("bypass_rd1", rd1_a, 32'hAAAA5678);

    // Hardwired zero entry versus ordinary entry 0.
    idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wmask = 4'b1111;
    re1 = 1'b1; raddr1 = 5'd0;
    step();
    check_val("zero_reg_bypass", rd1_a, 32'h0);
    check_val("plain_r0_bypass", rd1_b, 32'hFFFFFFFF);
    idle();
    re1 = 1'b1; raddr1 = 5'd0;
    step();
    check_val("zero_reg_later", rd1_a, 32'h0);
    check_val("plain_r0_later", rd1_b, 32'hFFFFFFFF);

    // Hold when read enable is low.
    idle();
    we = 1'b1; waddr = 5'd10; wdata = 32'h0000BEEF; wmask = 4'b1111;
    re0 = 1'b1; raddr0 = 5'd10;
    step();
    check_val("hold_setup", rd0_a, 32'h0000BEEF);
    re0 = 1'b0; raddr0 = 5'd7; wdata = 32'h12345678;
    step();
    waddr = 5'd11; raddr0 = 5'd11;
    step();
    check_val("hold_rd0", rd0_a, 32'h0000BEEF);

    // Reset dominates a simultaneous write and read.
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h5; wmask = 4'b1111;
    re0 = 1'b1; raddr0 = 5'd9;
    step();
    check_val("reset_mid_rd0", rd0_a, 32'h0);
    idle();
    re0 = 1'b1; raddr0 = 5'd9; re1 = 1'b1; raddr1 = 5'd7;
    step();
    check_val("reset_discard_w9", rd0_a, 32'h0);
    check_val("reset_cleared_e7", rd1_a, 32'h0);

    // Out-of-range address on the DEPTH=20 file.
    for (int i = 0; i < 20; i++) exp_c[i] = 32'h0;
    idle();
    we = 1'b1; wmask = 4'b1111;
    waddr = 5'd5;  wdata = 32'h05050505; exp_c[5]  = 32'h05050505;
    step();
    waddr = 5'd19; wdata = 32'h19191919; exp_c[19] = 32'h19191919;
    step();
    waddr = 5'd25; wdata = 32'hCAFEF00D;
    re0 = 1'b1; raddr0 = 5'd25;
    step();
    check_val("oor_read_c", rd0_c, 32'h0);
    check_val("in_range_a25", rd0_a, 32'hCAFEF00D);
    idle();
    re0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      raddr0 = 5'(i);
      step();
      check_val($sformatf("oor_readback_c[%0d]", i), rd0_c, exp_c[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
